// File: rtl/gbe_tx_frame_status.sv
// Frame classifier for the 10GbE TX FIFO write stream: counts good/bad frames,
// keeps sticky error flags and packs them into a 32-bit status word.
module gbe_tx_frame_status #(
   parameter int MAX_WORDS = 1024,
   parameter int LEN_W     = 11
) (
   input  logic        user_clk,
   input  logic        user_rst,
   input  logic        rst_cnt,
   input  logic        tx_valid,
   input  logic        tx_end_of_frame,
   input  logic        tx_overflow,
   input  logic        tx_afull,
   output logic [31:0] status_out,
   output logic        bad_frame
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_DROP   = 2'd2;

   localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MAX_WORDS);

   logic [1:0]       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [15:0]      good_q, good_d;
   logic [11:0]      bad_q, bad_d;
   logic             ovf_flag_q, ovf_flag_d;
   logic             size_flag_q, size_flag_d;
   logic             afull_flag_q, afull_flag_d;
   logic             bad_frame_q, bad_frame_d;

   logic             eof;
   logic [LEN_W:0]   len_inc;
   logic             oversize;
   logic             good_ev, bad_ev, size_ev;

   assign eof      = tx_valid & tx_end_of_frame;
   // One extra bit so len+1 cannot wrap when MAX_WORDS+1 == 2^LEN_W.
   assign len_inc  = {1'b0, len_q} + {{LEN_W{1'b0}}, 1'b1};
   assign oversize = (len_inc > MAX_LEN);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      good_ev = 1'b0;
      bad_ev  = 1'b0;
      size_ev = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (eof) begin
               if (tx_overflow) bad_ev = 1'b1;
               else             good_ev = 1'b1;
            end else if (tx_valid) begin
               len_d   = LEN_W'(1);
               state_d = tx_overflow ? S_DROP : S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            // Overflow poisons the frame; a word in the same cycle is handled as in DROP.
            if (tx_overflow) begin
               if (eof) begin
                  bad_ev  = 1'b1;
                  len_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DROP;
               end
            end else if (eof) begin
               len_d   = '0;
               state_d = S_IDLE;
               if (oversize) begin
                  bad_ev  = 1'b1;
                  size_ev = 1'b1;
               end else begin
                  good_ev = 1'b1;
               end
            end else if (tx_valid) begin
               if (oversize) begin
                  size_ev = 1'b1;
                  state_d = S_DROP;
               end else begin
                  len_d = len_inc[LEN_W-1:0];
               end
            end
         end
         S_DROP: begin
            if (eof) begin
               bad_ev  = 1'b1;
               len_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            len_d   = '0;
         end
      endcase
   end

   always_comb begin
      bad_frame_d = bad_ev;
      if (rst_cnt) begin
         good_d       = '0;
         bad_d        = '0;
         ovf_flag_d   = 1'b0;
         size_flag_d  = 1'b0;
         afull_flag_d = 1'b0;
      end else begin
         good_d       = good_q + {15'd0, good_ev};
         // Bad counter saturates rather than wrapping.
         bad_d        = (bad_ev && (bad_q != 12'hFFF)) ? bad_q + 12'd1 : bad_q;
         ovf_flag_d   = ovf_flag_q | tx_overflow;
         size_flag_d  = size_flag_q | size_ev;
         afull_flag_d = afull_flag_q | (tx_valid & tx_afull);
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         good_q       <= '0;
         bad_q        <= '0;
         ovf_flag_q   <= 1'b0;
         size_flag_q  <= 1'b0;
         afull_flag_q <= 1'b0;
         bad_frame_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         good_q       <= good_d;
         bad_q        <= bad_d;
         ovf_flag_q   <= ovf_flag_d;
         size_flag_q  <= size_flag_d;
         afull_flag_q <= afull_flag_d;
         bad_frame_q  <= bad_frame_d;
      end
   end

   assign status_out = {ovf_flag_q, size_flag_q, afull_flag_q, 1'b0, bad_q, good_q};
   assign bad_frame  = bad_frame_q;

endmodule

// File: tb/tb_gbe_tx_frame_status.sv
// Directed scoreboard bench for gbe_tx_frame_status: stimulus queues expected
// status/bad_frame values, a monitor on the falling edge pops and compares.
module tb_gbe_tx_frame_status;

   logic        clk = 1'b0;
   logic        user_rst;
   logic        rst_cnt;
   logic        tx_valid;
   logic        tx_end_of_frame;
   logic        tx_overflow;
   logic        tx_afull;
   logic [31:0] status_out;
   logic        bad_frame;

   always #5 clk = ~clk;

   gbe_tx_frame_status #(.MAX_WORDS(1024), .LEN_W(11)) dut (
      .user_clk        (clk),
      .user_rst        (user_rst),
      .rst_cnt         (rst_cnt),
      .tx_valid        (tx_valid),
      .tx_end_of_frame (tx_end_of_frame),
      .tx_overflow     (tx_overflow),
      .tx_afull        (tx_afull),
      .status_out      (status_out),
      .bad_frame       (bad_frame)
   );

   typedef struct {
      string       name;
      logic [31:0] st;
      logic        bad;
      int          pulses;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   pulse_cnt = 0;

   // Monitor: counts bad_frame pulses and checks whenever an expectation is pending.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bad_frame === 1'b1) pulse_cnt = pulse_cnt + 1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp = n_cmp + 1;
            if (status_out !== e.st) begin
               n_err = n_err + 1;
               $display("FAIL %s status: got %08h expected %08h", e.name, status_out, e.st);
            end
            n_cmp = n_cmp + 1;
            if (bad_frame !== e.bad) begin
               n_err = n_err + 1;
               $display("FAIL %s bad_frame: got %b expected %b", e.name, bad_frame, e.bad);
            end
            n_cmp = n_cmp + 1;
            if (pulse_cnt != e.pulses) begin
               n_err = n_err + 1;
               $display("FAIL %s pulse count: got %0d expected %0d", e.name, pulse_cnt, e.pulses);
            end
            pulse_cnt = 0;
         end
      end
   end

   task automatic send(input logic v, input logic eo, input logic o, input logic a, input logic r);
      @(posedge clk);
      #1;
      tx_valid        = v;
      tx_end_of_frame = eo;
      tx_overflow     = o;
      tx_afull        = a;
      rst_cnt         = r;
   endtask

   task automatic idle();
      send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Expectation for the state after the inputs driven by the previous send.
   task automatic chk(input string name, input logic [31:0] st, input logic bad, input int pulses);
      exp_t e;
      e.name   = name;
      e.st     = st;
      e.bad    = bad;
      e.pulses = pulses;
      exp_q.push_back(e);
   endtask

   task automatic clear_cnt();
      send(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      tx_valid = 1'b0; tx_end_of_frame = 1'b0; tx_overflow = 1'b0;
      tx_afull = 1'b0; rst_cnt = 1'b0; user_rst = 1'b1;
      @(posedge clk);
      #1;
      user_rst = 1'b0;
   endtask

   initial begin
      user_rst = 1'b1; rst_cnt = 1'b0; tx_valid = 1'b0;
      tx_end_of_frame = 1'b0; tx_overflow = 1'b0; tx_afull = 1'b0;
      idle();
      idle();
      chk("reset", 32'h0000_0000, 1'b0, 0);
      user_rst = 1'b0;

      // Three back-to-back 8-word frames.
      for (int f = 0; f < 3; f++) begin
         for (int w = 1; w <= 8; w++) begin
            send(1'b1, (w == 8), 1'b0, 1'b0, 1'b0);
            if (f > 0 && w == 1) chk("t1_frame", 32'(f), 1'b0, 0);
         end
      end
      idle();
      chk("t1_three_frames", 32'h0000_0003, 1'b0, 0);

      // 1024-word frame (legal), then 1025 (oversize at eof), then 1027 (oversize mid-frame).
      clear_cnt();
      chk("t2_clear", 32'h0000_0000, 1'b0, 0);
      for (int w = 1; w <= 1024; w++) send(1'b1, (w == 1024), 1'b0, 1'b0, 1'b0);
      for (int w = 1; w <= 1025; w++) begin
         send(1'b1, (w == 1025), 1'b0, 1'b0, 1'b0);
         if (w == 1) chk("t2_max_len", 32'h0000_0001, 1'b0, 0);
      end
      idle();
      chk("t2_oversize_eof", 32'h4001_0001, 1'b1, 1);
      idle();
      chk("t2_pulse_end", 32'h4001_0001, 1'b0, 0);
      for (int w = 1; w <= 1027; w++) send(1'b1, (w == 1027), 1'b0, 1'b0, 1'b0);
      idle();
      chk("t2_oversize_mid", 32'h4002_0001, 1'b1, 1);

      // Overflow at word 5 of 10, then a clean 4-word frame.
      clear_cnt();
      for (int w = 1; w <= 10; w++) begin
         send(1'b1, (w == 10), (w == 5), 1'b0, 1'b0);
         if (w == 10) chk("t3_pre_eof", 32'h8000_0000, 1'b0, 0);
      end
      idle();
      chk("t3_bad_eof", 32'h8001_0000, 1'b1, 1);
      for (int w = 1; w <= 4; w++) send(1'b1, (w == 4), 1'b0, 1'b0, 1'b0);
      idle();
      chk("t3_clean", 32'h8001_0001, 1'b0, 0);

      // Write-while-afull flag, then rst_cnt colliding with eof.
      clear_cnt();
      send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_afull_flag", 32'h2000_0000, 1'b0, 0);
      send(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      idle();
      chk("t5_rstcnt_eof", 32'h0000_0000, 1'b0, 0);
      send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      chk("t5_after_clear", 32'h0000_0001, 1'b0, 0);
      send(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      idle();
      chk("t5_rstcnt_bad", 32'h0000_0000, 1'b1, 1);

      // Reset mid-frame discards the partial frame.
      send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int w = 1; w <= 3; w++) send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_reset();
      chk("t6_reset_mid", 32'h0000_0000, 1'b0, 0);
      for (int w = 1; w <= 3; w++) send(1'b1, (w == 3), 1'b0, 1'b0, 1'b0);
      idle();
      chk("t6_new_frame", 32'h0000_0001, 1'b0, 0);
      for (int w = 1; w <= 3; w++) send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_reset();
      send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int w = 1; w <= 3; w++) send(1'b1, (w == 3), 1'b0, 1'b0, 1'b0);
      idle();
      chk("t6_idle_ovf", 32'h8000_0001, 1'b0, 0);

      // Bad counter saturation and good counter wrap.
      clear_cnt();
      for (int i = 0; i < 4101; i++) send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 65537; i++) begin
         send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         if (i == 0) chk("t4_bad_sat", 32'h8FFF_0000, 1'b1, 4101);
      end
      idle();
      chk("t4_good_wrap", 32'h8FFF_0001, 1'b0, 0);

      repeat (3) @(posedge clk);
      n_cmp = n_cmp + 1;
      if (exp_q.size() != 0) begin
         n_err = n_err + 1;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gbe_tx_frame_status.md
# gbe_tx_frame_status

Frame-level monitor on the 10GbE transmit interface, in the user clock domain. It watches the word stream written into the 10GbE core TX FIFO and classifies each frame as good or bad. It keeps wrapping and saturating frame counters plus sticky error flags. Its packed 32-bit `status_out` feeds directly into the `user_data_in` port of the bframe status register, which the PPC reads over OPB.

## Interface
Parameters:
- `MAX_WORDS`, default 1024: largest legal frame length in 64-bit words; range 2..2047.
- `LEN_W`, default 11: width of the frame word counter; must satisfy 2^LEN_W > MAX_WORDS.

Ports:
- `user_clk`  in  1  the block's single clock.
- `user_rst`  in  1  synchronous, active-high reset.
- `rst_cnt`  in  1  synchronous counter/flag clear from a software register; level-sensitive.
- `tx_valid`  in  1  one data word is written to the TX FIFO this cycle.
- `tx_end_of_frame`  in  1  marks the last word of a frame; ignored unless `tx_valid`=1.
- `tx_overflow`  in  1  TX FIFO overflow indication from the core.
- `tx_afull`  in  1  TX FIFO almost-full from the core.
- `status_out`  out  32  packed status word, registered.
- `bad_frame`  out  1  one-cycle pulse per frame classified bad.

## Operation
- `status_out` layout:
  - [31]: sticky overflow seen.
  - [30]: sticky oversize frame seen.
  - [29]: sticky write-while-afull seen (`tx_valid`=1 and `tx_afull`=1).
  - [28]: constant 0.
  - [27:16]: bad frame count, 12-bit, saturates at 0xFFF.
  - [15:0]: good frame count, 16-bit, wraps 0xFFFF->0x0000.
- Internal word counter `len` (LEN_W bits) holds the number of words of the current frame accepted so far.
- FSM states and transitions:
  - IDLE (no frame in progress):
    - valid and eof: a 1-word frame. It is bad if `tx_overflow`=1 this cycle, otherwise good. Stay in IDLE.
    - valid and not eof: set len=1. Go to DROP if `tx_overflow`=1, else ACTIVE.
  - ACTIVE:
    - `tx_overflow`=1: go to DROP; a word accepted in the same cycle is counted into DROP.
    - Otherwise valid and eof: the frame has len+1 words. It is good if len+1 ≤ MAX_WORDS, else bad with flag [30] set. Clear len, go to IDLE.
    - Otherwise valid and not eof: if len+1 > MAX_WORDS, set flag [30] and go to DROP; else len<=len+1.
  - DROP (current frame already bad):
    - Absorb words.
    - On valid and eof: count bad, pulse `bad_frame`, clear len, go to IDLE.
    - `len` is not advanced in DROP.
- `tx_overflow` in IDLE with `tx_valid`=0 sets flag [31] only; it marks no frame bad.
- `tx_overflow`=1 in any state sets flag [31].
- Each frame increments exactly one counter, once, in the eof cycle.
- `rst_cnt`=1 clears both counters and all flags. It does not touch the FSM or `len`, so a frame in progress is still classified at its eof.
- Simultaneous eof and `rst_cnt`: the clear wins. The counters read 0 afterwards; `bad_frame` still pulses if the frame is bad.

## Timing
- Reset: with `user_rst`=1 at a rising edge, the next cycle has state=IDLE, len=0, `status_out`=0x00000000 and `bad_frame`=0.
- `user_rst` overrides `rst_cnt` and all inputs. Reset mid-frame discards the frame: no counter moves, and the remaining words up to eof are treated as a new frame.
- Latency: an eof word accepted on cycle N is reflected in `status_out` and in the `bad_frame` pulse on cycle N+1.
- Sticky flags appear in `status_out` one cycle after the causing input.
- No backpressure: the block accepts every `tx_valid` word. Throughput is one word per cycle, and frames may be back-to-back with no idle cycles.
- `status_out` changes only on `user_clk`. Clock-domain crossing is handled by the downstream status register.

## Test plan
- Reset, then 3 frames of 8 words each, back-to-back -> `status_out`=0x00000003, `bad_frame` never asserted.
- With MAX_WORDS=1024: one frame of 1024 words, then one frame of 1025 words -> `status_out`=0x40010001, `bad_frame` pulses once, on the cycle after the 1025th word.
- `tx_overflow` pulsed at word 5 of a 10-word frame, then one clean 4-word frame -> `status_out`=0x80010001; the bad count increments only at word 10's eof+1.
- 4096+5 bad single-word frames (`tx_overflow` held high) plus 65537 good frames -> bad field=0xFFF (saturated), good field=0x0001.
- Assert `rst_cnt` on the same cycle as a good frame's eof, with an earlier `tx_valid`+`tx_afull` -> next cycle `status_out`=0x00000000; the following good frame gives 0x00000001.
- Assert `user_rst` in the middle of a 6-word frame (after word 3), then send 3 words with eof on the last -> `status_out`=0x00000001.
